// File: rtl/button_event_ctrl_pkg.sv
// button_event_ctrl_pkg: per-button FSM encoding, event kinds and parameter helpers
package button_event_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } btn_state_e;
  localparam logic EVT_PRESS  = 1'b0;
  localparam logic EVT_REPEAT = 1'b1;
  function automatic bit fits_cnt(int unsigned v, int unsigned w);
    return v != 0 && (v >> w) == 0;
  endfunction
endpackage

// File: rtl/button_event_ctrl_if.sv
// button_event_ctrl_if: timebase, button levels and the shared key-event strobe
interface button_event_ctrl_if #(
  parameter int NUM_BTN = 5,
  parameter int ID_W    = 3
);
  logic               tick;
  logic [NUM_BTN-1:0] btn_sync;
  logic               evt_valid;
  logic [ID_W-1:0]    evt_id;
  logic               evt_repeat;
  modport master (output tick, btn_sync, input evt_valid, evt_id, evt_repeat);
  modport slave (input tick, btn_sync, output evt_valid, evt_id, evt_repeat);
endinterface

// File: rtl/button_event_ctrl_btn_fsm.sv
// btn_fsm: debounce, press detection and hold-to-repeat for a single button
module btn_fsm
  import button_event_ctrl_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 100,
  parameter int REPEAT_TICKS   = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic ev_pulse,
  output logic ev_kind
);
  localparam logic [CNT_W-1:0] DB_T   = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(REPEAT_TICKS);
  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // a level change always wins over a coincident tick
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ev_pulse = 1'b0;
    ev_kind  = EVT_PRESS;
    case (state_q)
      IDLE:
        if (btn) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      PRESS_DB:
        if (!btn) state_d = IDLE;
        else if (tick && cnt_inc == DB_T) begin
          state_d  = HELD;
          cnt_d    = '0;
          ev_pulse = 1'b1;
        end else if (tick) cnt_d = cnt_inc;
      HELD, REPEAT:
        if (!btn) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (tick && cnt_inc == ((state_q == HELD) ? HOLD_T : RPT_T)) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          ev_pulse = 1'b1;
          ev_kind  = EVT_REPEAT;
        end else if (tick) cnt_d = cnt_inc;
      REL_DB:
        if (btn) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (tick && cnt_inc == DB_T) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) cnt_d = cnt_inc;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: per-button key event FSMs sharing one event strobe
// through a pending register and a fixed lowest-index-first arbiter.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int NUM_BTN        = 5,
  parameter int CNT_W          = 8,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 100,
  parameter int REPEAT_TICKS   = 25,
  parameter int ID_W           = 3
) (
  input logic clk,
  input logic reset,
  button_event_ctrl_if.slave bus
);
  logic [NUM_BTN-1:0] ev_pulse, ev_kind, pend_q, pend_d, kind_q, kind_d, grant, take;
  logic evt_valid_q, evt_valid_d, evt_repeat_q, evt_repeat_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  if (!fits_cnt(DEBOUNCE_TICKS, CNT_W) || !fits_cnt(HOLD_TICKS, CNT_W) || !fits_cnt(REPEAT_TICKS, CNT_W)) begin : g_bad_cnt
    $error("tick thresholds must be nonzero and below 2**CNT_W");
  end
  if (NUM_BTN < 1 || ((NUM_BTN - 1) >> ID_W) != 0) begin : g_bad_id
    $error("ID_W too narrow for NUM_BTN");
  end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_fsm #(
      .CNT_W(CNT_W),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS(HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_fsm (
      .clk(clk),
      .reset(reset),
      .tick(bus.tick),
      .btn(bus.btn_sync[i]),
      .ev_pulse(ev_pulse[i]),
      .ev_kind(ev_kind[i])
    );
  end
  // new events are dropped while pending unless that slot is granted this cycle
  always_comb begin
    grant        = pend_q & (~pend_q + 1'b1);
    take         = ev_pulse & (~pend_q | grant);
    pend_d       = ev_pulse | (pend_q & ~grant);
    kind_d       = (take & ev_kind) | (~take & kind_q);
    evt_valid_d  = |pend_q;
    evt_repeat_d = |(grant & kind_q);
    evt_id_d     = '0;
    for (int i = 0; i < NUM_BTN; i++) evt_id_d = grant[i] ? ID_W'(i) : evt_id_d;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_q       <= '0;
      kind_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      kind_q       <= kind_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_repeat_q <= evt_repeat_d;
    end
  assign bus.evt_valid  = evt_valid_q;
  assign bus.evt_id     = evt_id_q;
  assign bus.evt_repeat = evt_repeat_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: vector table, directed corner sequences and a randomized
// run, all compared cycle by cycle against a run-length based reference model.
module tb_button_event_ctrl;
  localparam int NB   = 5;
  localparam int DB   = 10;
  localparam int HOLD = 100;
  localparam int RPT  = 25;
  typedef struct {
    logic [NB-1:0] mask;
    int nticks;
    int exp_events;
    int exp_id;
    int exp_rep;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NB-1:0] rb;
  int checks = 0;
  int errors = 0;
  int ev_seen = 0;
  int last_id = 0;
  int last_rep = 0;
  int run [NB];
  int base [NB];
  bit prs [NB];
  bit prev [NB];
  bit pend [NB];
  bit kind [NB];
  bit m_valid, m_rep;
  int m_id;
  vec_t vecs [8];
  always #5 clk = ~clk;
  button_event_ctrl_if #(.NUM_BTN(NB), .ID_W(3)) bus ();
  button_event_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // run[i] = ticks seen during the current level run, not counting the cycle the level changed
  task automatic model_edge(input bit t, input logic [NB-1:0] b);
    bit ev, evk;
    m_valid = 0;
    m_id = 0;
    m_rep = 0;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        run[i] = 0; base[i] = 0; prs[i] = 0; prev[i] = 0; pend[i] = 0; kind[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NB; i++)
      if (pend[i] && !m_valid) begin
        m_valid = 1; m_id = i; m_rep = kind[i]; pend[i] = 0;
      end
    for (int i = 0; i < NB; i++) begin
      ev = 0;
      evk = 0;
      if (b[i] != prev[i]) begin
        run[i] = 0;
        if (b[i] && prs[i]) base[i] = 0;
      end else if (t) begin
        run[i]++;
        if (!prs[i] && b[i] && run[i] == DB) begin
          prs[i] = 1; base[i] = DB; ev = 1;
        end else if (prs[i] && b[i] && run[i] - base[i] >= HOLD && (run[i] - base[i] - HOLD) % RPT == 0) begin
          ev = 1; evk = 1;
        end else if (prs[i] && !b[i] && run[i] == DB) prs[i] = 0;
      end
      prev[i] = b[i];
      if (ev && !pend[i]) begin
        pend[i] = 1; kind[i] = evk;
      end
    end
  endtask

  task automatic cycle(input bit t, input logic [NB-1:0] b);
    bus.tick = t;
    bus.btn_sync = b;
    @(posedge clk);
    model_edge(t, b);
    #1;
    check("evt_valid", int'(bus.evt_valid), int'(m_valid));
    if (m_valid || reset) begin
      check("evt_id", int'(bus.evt_id), m_id);
      check("evt_repeat", int'(bus.evt_repeat), int'(m_rep));
    end
    if (bus.evt_valid) begin
      ev_seen++;
      last_id = int'(bus.evt_id);
      last_rep = int'(bus.evt_repeat);
    end
  endtask

  task automatic ticks(input int n, input logic [NB-1:0] b);
    for (int k = 0; k < n; k++) begin
      cycle(0, b); cycle(0, b); cycle(0, b); cycle(1, b);
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.btn_sync = '0;
    rb = '0;
    vecs[0] = '{5'b00100, 20, 1, 2, 0};
    vecs[1] = '{5'b10000, 190, 5, 4, 1};
    vecs[2] = '{5'b01010, 20, 2, 3, 0};
    vecs[3] = '{5'b00001, 9, 0, 0, 0};
    vecs[4] = '{5'b00001, 10, 1, 0, 0};
    vecs[5] = '{5'b00010, 109, 1, 1, 0};
    vecs[6] = '{5'b00010, 110, 2, 1, 1};
    vecs[7] = '{5'b11111, 10, 5, 4, 0};
    repeat (3) cycle(0, '0);
    reset = 1'b0;
    ticks(250, '0);
    check("idle_quiet", ev_seen, 0);

    ev_seen = 0;
    ticks(10, 5'b00100);
    check("press_not_early", ev_seen, 0);
    cycle(0, 5'b00100);
    check("press_valid", int'(bus.evt_valid), 1);
    check("press_id", int'(bus.evt_id), 2);
    check("press_rep", int'(bus.evt_repeat), 0);
    ticks(10, 5'b00100);
    ticks(15, '0);
    check("press_once", ev_seen, 1);

    ev_seen = 0;
    ticks(10, 5'b01010);
    cycle(0, 5'b01010);
    check("contend_first_valid", int'(bus.evt_valid), 1);
    check("contend_first_id", int'(bus.evt_id), 1);
    cycle(0, 5'b01010);
    check("contend_second_valid", int'(bus.evt_valid), 1);
    check("contend_second_id", int'(bus.evt_id), 3);
    check("contend_second_rep", int'(bus.evt_repeat), 0);
    ticks(5, 5'b01010);
    ticks(15, '0);
    check("contend_count", ev_seen, 2);

    ev_seen = 0;
    for (int k = 0; k < 10; k++) ticks(3, (k % 2 == 0) ? 5'b00001 : 5'b00000);
    ticks(9, 5'b00001);
    check("bounce_not_early", ev_seen, 0);
    ticks(1, 5'b00001);
    cycle(0, 5'b00001);
    check("bounce_valid", int'(bus.evt_valid), 1);
    check("bounce_id", int'(bus.evt_id), 0);
    ticks(15, '0);
    check("bounce_once", ev_seen, 1);

    ev_seen = 0;
    ticks(9, 5'b01000);
    reset = 1'b1;
    cycle(0, 5'b01000);
    cycle(0, 5'b01000);
    reset = 1'b0;
    ticks(9, 5'b01000);
    check("reset_no_stale", ev_seen, 0);
    ticks(1, 5'b01000);
    cycle(0, 5'b01000);
    check("reset_press_valid", int'(bus.evt_valid), 1);
    check("reset_press_id", int'(bus.evt_id), 3);
    check("reset_press_rep", int'(bus.evt_repeat), 0);
    ticks(15, '0);

    foreach (vecs[v]) begin
      ev_seen = 0;
      ticks(vecs[v].nticks, vecs[v].mask);
      ticks(15, '0);
      check($sformatf("vec%0d_events", v), ev_seen, vecs[v].exp_events);
      if (vecs[v].exp_events > 0) begin
        check($sformatf("vec%0d_last_id", v), last_id, vecs[v].exp_id);
        check($sformatf("vec%0d_last_rep", v), last_rep, vecs[v].exp_rep);
      end
    end

    for (int c = 0; c < 8000; c++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 249) == 0) rb[i] = ~rb[i];
      reset = ($urandom_range(0, 2999) == 0);
      cycle(bit'($urandom_range(0, 3) == 0), rb);
    end
    reset = 1'b0;
    ticks(15, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Sequences the synchronized push-button lines of the alarm clock into clean key events. Per button: tick-based debounce, press detection, and hold-to-auto-repeat. A fixed-priority arbiter then shares the single event output among all buttons. It sits between the per-button synchronizers and the clock/alarm mode FSM, which consumes one `evt_valid` pulse per key action.

## Interface
- `NUM_BTN`, 5: number of button channels.
- `CNT_W`, 8: width of the per-button tick counter.
- `DEBOUNCE_TICKS`, 10: ticks of a stable level required to accept a press or a release.
- `HOLD_TICKS`, 100: ticks held after an accepted press before the first repeat.
- `REPEAT_TICKS`, 25: ticks between subsequent repeats.
- `ID_W`, 3: width of the button index; must satisfy 2^ID_W ≥ NUM_BTN.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `tick` in 1: single-cycle timebase enable (e.g. 1 kHz); all counters advance only on `tick`.
- `btn_sync` in NUM_BTN: already-synchronized button levels, 1 = pressed.
- `evt_valid` out 1: registered one-cycle event strobe.
- `evt_id` out ID_W: index of the button owning the event; valid only with `evt_valid`.
- `evt_repeat` out 1: 0 = initial press, 1 = auto-repeat; valid only with `evt_valid`.

## Operation
- Per-button FSM states: IDLE, PRESS_DB, HELD, REPEAT, REL_DB. Each button has its own `cnt` (CNT_W).
- IDLE: on `btn_sync`=1, go to PRESS_DB with cnt=0.
- PRESS_DB:
  - `btn_sync`=0 → IDLE, no event.
  - On tick, cnt+1; when cnt reaches DEBOUNCE_TICKS → HELD, cnt=0, raise a press event.
- HELD:
  - `btn_sync`=0 → REL_DB, cnt=0.
  - On tick, cnt+1; when cnt reaches HOLD_TICKS → REPEAT, cnt=0, raise a repeat event.
- REPEAT:
  - `btn_sync`=0 → REL_DB, cnt=0.
  - On tick, cnt+1; when cnt reaches REPEAT_TICKS → cnt=0, raise a repeat event, stay in REPEAT.
- REL_DB:
  - `btn_sync`=1 → HELD, cnt=0. This is a bounce: no new press event, and the repeat schedule restarts.
  - On tick, cnt+1; when cnt reaches DEBOUNCE_TICKS → IDLE.
- Level change has priority: if `btn_sync` changes in the same cycle as `tick`, take the level transition and do not count the tick.
- Counter width: no wrap is possible because every threshold must be below 2^CNT_W. Enforce this with an elaboration-time check.
- Pending register (per button):
  - An event sets `pend[i]=1` and stores `kind[i]`.
  - If pend[i] is already set, the new event is dropped.
  - Exception: a new event in the same cycle the arbiter clears pend[i] sets it again (set wins).
- Arbiter:
  - Each cycle, the lowest index i with pend[i]=1 wins.
  - On the next edge: `evt_valid`=1, `evt_id`=i, `evt_repeat`=kind[i], and pend[i] clears.
  - Exactly one event is granted per cycle.

## Timing
- Reset values: all FSMs IDLE, all cnt=0, pend=0, kind=0, `evt_valid`=0, `evt_id`=0, `evt_repeat`=0.
- Reset asserted mid-operation discards all FSM state and pending events immediately; no event is emitted on release.
- Latency: the event is raised on the edge where cnt reaches threshold; `evt_valid` is high on the following edge (1 clk), if uncontended.
- Contention: with k simultaneous pending events, the last grant occurs k cycles after they are raised. Order is ascending index.
- `evt_valid` is never high for two consecutive cycles from the same press. Back-to-back pulses from different buttons are permitted.
- `tick` is asynchronous to events only logically. It must be a single `clk`-wide pulse in the `clk` domain.

## Structure
- Shared package/header:
  - FSM state encoding (IDLE=0, PRESS_DB=1, HELD=2, REPEAT=3, REL_DB=4, 3 bits).
  - Event-kind constants (EVT_PRESS=0, EVT_REPEAT=1).
- Sub-module `btn_fsm`:
  - One instance per button via generate.
  - Ports: clk, reset, tick, btn, ev_pulse, ev_kind.
- Top-level logic: the pending register and the priority arbiter, plus the parameter checks.

## Test plan
- Reset then idle, with `tick` every 4 clk: `evt_valid` stays 0 for 1000 clk.
- Clean press on btn 2 (DEBOUNCE_TICKS=10), held 20 ticks, then released: exactly one event, id=2, repeat=0, 1 clk after the 10th tick. No event on release.
- Bounce on btn 0: the level toggles every 3 ticks for 30 ticks, then stays stable high. There is exactly one press event, 10 ticks after the final rise.
- Hold on btn 4 for 100+3×25 ticks:
  - press event at tick 10, then repeat events at ticks 110, 135, 160 and 185;
  - all with id=4, repeat=1.
- Buttons 1 and 3 cross debounce on the same cycle: id=1 is granted first, then id=3 on the next clk. Both have repeat=0.
- Reset asserted while btn 3 is in PRESS_DB at cnt=9, released 2 clk later with the button still high:
  - no stale event;
  - the press event comes 10 ticks after reset release.
